uart_dbg_master: RTL

UART-driven bus initiator for the debug path. A host PC sends command frames over rx_pin; the block decodes them and drives the same simple register bus the uart peripheral responds on (we/waddr/raddr/wdata/rdata), then returns an acknowledgement or read data over tx_pin. Fixed 8N1 framing, half-duplex command/response.

---
 rtl/uart_dbg_pkg.sv | 9 +
 rtl/uart_byte_rx.sv | 78 +++++++
 rtl/uart_dbg_master.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_dbg_pkg.sv
// uart_dbg_pkg: command/response codes and FSM state encodings for the UART debug master.
package uart_dbg_pkg;
  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;
  typedef enum logic [2:0] {S_CMD, S_ADDR, S_WDATA, S_BUS_WR, S_BUS_RD, S_RESP} state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 receiver with input synchronizer, start-bit validation and mid-bit sampling.
module uart_byte_rx
  import uart_dbg_pkg::*;
#(
  parameter logic [15:0] CLK_DIV = 16'd440
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       err_o
);
  localparam logic [15:0] HALF_M1 = 16'((32'(CLK_DIV) + 32'd1) / 32'd2 - 32'd1);
  rx_state_e   st_q, st_d;
  logic [2:0]  sync_q, sync_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic        valid_q, valid_d, err_q, err_d;
  logic        rx_s;
  // sync_q[1] is the synchronized line, sync_q[2] its previous value for edge detection
  assign rx_s = sync_q[1];
  always_comb begin
    sync_d  = {sync_q[1:0], rx_pin};
    st_d    = st_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (sync_q[2] && !rx_s) st_d = RX_START;
      end
      RX_START: if (cnt_q == HALF_M1) begin
        cnt_d = '0;
        idx_d = '0;
        st_d  = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == CLK_DIV) begin
        cnt_d = '0;
        sh_d  = {rx_s, sh_q[7:1]};
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) st_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == CLK_DIV) begin
        valid_d = rx_s;
        err_d   = !rx_s;
        st_d    = RX_IDLE;
      end
      default: st_d = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= RX_IDLE;
      sync_q  <= 3'b111;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  assign data_o  = sh_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;
endmodule

// File: rtl/uart_dbg_master.sv
// uart_dbg_master: UART command decoder driving a simple register bus, replying over a TX serializer.
module uart_dbg_master
  import uart_dbg_pkg::*;
#(
  parameter logic [15:0] CLK_DIV      = 16'd440,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_pin,
  output logic        tx_pin,
  output logic        bus_we_o,
  output logic [31:0] bus_waddr_o,
  output logic [31:0] bus_wdata_o,
  output logic [31:0] bus_raddr_o,
  input  logic [31:0] bus_rdata_i,
  output logic        busy_o,
  output logic        frame_err_o,
  output logic        timeout_o
);
  localparam logic [31:0] TMO_M1   = 32'(TIMEOUT_BITS * (32'(CLK_DIV) + 32'd1) - 32'd1);
  localparam logic [7:0]  RD_LAT_C = 8'(RD_LAT);
  state_e      st_q, st_d;
  logic        is_wr_q, is_wr_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, raddr_q, raddr_d, rsp_q, rsp_d, tmo_q, tmo_d;
  logic [2:0]  nleft_q, nleft_d;
  logic [7:0]  rd_cnt_q, rd_cnt_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  rx_data;
  logic        rx_valid;
  uart_byte_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk    (clk),
    .rst    (rst),
    .rx_pin (rx_pin),
    .data_o (rx_data),
    .valid_o(rx_valid),
    .err_o  (frame_err_o)
  );
  always_comb begin
    st_d      = st_q;
    is_wr_d   = is_wr_q;
    bcnt_d    = bcnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    raddr_d   = raddr_q;
    rsp_d     = rsp_q;
    nleft_d   = nleft_q;
    tmo_d     = '0;
    rd_cnt_d  = '0;
    tx_bit_d  = '0;
    tx_cnt_d  = '0;
    timeout_d = 1'b0;
    case (st_q)
      S_CMD: begin
        bcnt_d = '0;
        if (rx_valid) begin
          is_wr_d = rx_data == CMD_WR;
          if (rx_data == CMD_WR || rx_data == CMD_RD) st_d = S_ADDR;
          else begin
            rsp_d   = {24'd0, RSP_ERR};
            nleft_d = 3'd1;
            st_d    = S_RESP;
          end
        end
      end
      S_ADDR, S_WDATA: begin
        tmo_d = tmo_q + 32'd1;
        if (rx_valid) begin
          tmo_d  = '0;
          bcnt_d = bcnt_q + 2'd1;
          if (st_q == S_ADDR) addr_d = {rx_data, addr_q[31:8]};
          else wdata_d = {rx_data, wdata_q[31:8]};
          if (bcnt_q == 2'd3) begin
            st_d    = st_q == S_WDATA ? S_BUS_WR : is_wr_q ? S_WDATA : S_BUS_RD;
            raddr_d = (st_q == S_ADDR && !is_wr_q) ? {rx_data, addr_q[31:8]} : raddr_q;
          end
        end else if (tmo_q == TMO_M1) begin
          timeout_d = 1'b1;
          st_d      = S_CMD;
        end
      end
      S_BUS_WR: begin
        rsp_d   = {24'd0, RSP_ACK};
        nleft_d = 3'd1;
        st_d    = S_RESP;
      end
      S_BUS_RD: begin
        rd_cnt_d = rd_cnt_q + 8'd1;
        if (rd_cnt_q == RD_LAT_C) begin
          rsp_d   = bus_rdata_i;
          nleft_d = 3'd4;
          st_d    = S_RESP;
        end
      end
      S_RESP: begin
        tx_bit_d = tx_bit_q;
        tx_cnt_d = tx_cnt_q + 16'd1;
        if (tx_cnt_q == CLK_DIV) begin
          tx_cnt_d = '0;
          tx_bit_d = tx_bit_q + 4'd1;
          // after the stop bit, move to the next buffered byte or finish
          if (tx_bit_q == 4'd9) begin
            tx_bit_d = '0;
            rsp_d    = rsp_q >> 8;
            nleft_d  = nleft_q - 3'd1;
            if (nleft_q == 3'd1) st_d = S_CMD;
          end
        end
      end
      default: st_d = S_CMD;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q      <= S_CMD;
      is_wr_q   <= 1'b0;
      bcnt_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      raddr_q   <= '0;
      rsp_q     <= '0;
      nleft_q   <= '0;
      tmo_q     <= '0;
      rd_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      is_wr_q   <= is_wr_d;
      bcnt_q    <= bcnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      raddr_q   <= raddr_d;
      rsp_q     <= rsp_d;
      nleft_q   <= nleft_d;
      tmo_q     <= tmo_d;
      rd_cnt_q  <= rd_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_cnt_q  <= tx_cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign tx_pin      = (st_q != S_RESP || tx_bit_q >= 4'd9) ? 1'b1 :
                       tx_bit_q == 4'd0 ? 1'b0 : rsp_q[3'(tx_bit_q - 4'd1)];
  assign bus_we_o    = st_q == S_BUS_WR;
  assign bus_waddr_o = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_raddr_o = raddr_q;
  assign busy_o      = st_q != S_CMD;
  assign timeout_o   = timeout_q;
endmodule
